// File: rtl/sum_carry_pkg.sv
// -----------------------------------------------------------------------------
// sum_carry_pkg
//   Shared types and helpers for the sum/carry pair packer.
//   - asm_state_e   : assembler FSM state (IDLE = no pairs held, FILL = 1+ held)
//   - place_pair()  : positions one {cout, a} pair at its index in a word
//   - W_DEFAULT / DEPTH_DEFAULT : default word width and FIFO depth
// -----------------------------------------------------------------------------
package sum_carry_pkg;

  localparam int unsigned W_DEFAULT     = 8;
  localparam int unsigned DEPTH_DEFAULT = 2;

  // Widest word place_pair() can build; callers truncate to their own width.
  localparam int unsigned PAIR_MAX_W    = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } asm_state_e;

  // Pair k occupies bits [2k+1:2k] as {cout, a}; every other bit is zero.
  function automatic logic [PAIR_MAX_W-1:0] place_pair(
    input logic        a,
    input logic        cout,
    input int unsigned idx
  );
    logic [PAIR_MAX_W-1:0] w_word;
    w_word      = '0;
    w_word[1:0] = {cout, a};
    return w_word << (2 * idx);
  endfunction

endpackage

// File: rtl/pack_fifo.sv
// -----------------------------------------------------------------------------
// pack_fifo
//   Small synchronous FIFO with a registered head (no fall-through): a word
//   pushed into an empty FIFO is visible on o_head_data the following cycle.
//   Simultaneous push and pop while not full keeps the count unchanged.
//   Pushes into a full FIFO and pops from an empty FIFO are ignored.
//
// Parameters
//   WIDTH  entry width in bits
//   DEPTH  number of entries (power of two, >= 2)
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   i_push         write i_push_data at the tail
//   i_push_data    entry to write
//   i_pop          discard the head entry
//   o_head_data    entry at the head (all zero after reset)
//   o_full         DEPTH entries held
//   o_empty        no entries held
//   o_count        number of entries held
// -----------------------------------------------------------------------------
module pack_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Head comes straight out of the storage registers.
  assign o_head_data = r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sum_carry_packer.sv
// -----------------------------------------------------------------------------
// sum_carry_packer
//   Collects one (A, cout) bit pair per accepted beat into a W-bit word
//   (pair k at bits [2k+1:2k] as {cout, a}) and queues finished words in a
//   DEPTH-entry FIFO presented on a valid/ready output.
//
// Handshakes (both sides): a transfer happens on a rising clock edge where
// valid and ready are both high; valid-side data is held until then.
// in_ready is a function of registers only, so a pop in the same cycle never
// frees room for a push into a full FIFO.
//
// Optional build macro
//   PACK_PARITY_EN : adds out_parity, the XOR of the head word, computed when
//                    the word is pushed and stored alongside it.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready input pair handshake; in_a = sum bit, in_cout = carry bit
//   flush             commit the partial word (zero-padded, out_partial=1)
//   out_valid/out_ready output word handshake
//   out_data          packed word at the FIFO head
//   out_partial       head word was committed by flush with < PAIRS pairs
//   o_dbg_state       assembler FSM state
//   o_dbg_fifo_count  number of words queued
//   out_parity        (PACK_PARITY_EN only) XOR-reduction of out_data
// -----------------------------------------------------------------------------
module sum_carry_packer
  import sum_carry_pkg::*;
#(
  parameter int unsigned W     = W_DEFAULT,
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       in_a,
  input  logic                       in_cout,
  output logic                       in_ready,
  input  logic                       flush,
  output logic                       out_valid,
  output logic [W-1:0]               out_data,
  output logic                       out_partial,
  input  logic                       out_ready,
  output logic                       o_dbg_state,
  output logic [$clog2(DEPTH+1)-1:0] o_dbg_fifo_count
`ifdef PACK_PARITY_EN
  ,
  output logic                       out_parity
`endif
);

  localparam int unsigned PAIRS = W / 2;
  localparam int unsigned CNTW  = $clog2(PAIRS);
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(PAIRS - 1);
`ifdef PACK_PARITY_EN
  localparam int unsigned ENTRY_W = W + 2;  // {parity, partial, word}
`else
  localparam int unsigned ENTRY_W = W + 1;  // {partial, word}
`endif

  asm_state_e      r_state;
  asm_state_e      w_state_next;
  logic [CNTW-1:0] r_cnt;
  logic [CNTW-1:0] w_cnt_next;
  logic [W-1:0]    r_asm;
  logic [W-1:0]    w_asm_next;

  logic               w_accept;
  logic               w_last;
  logic               w_complete;
  logic               w_push;
  logic               w_push_partial;
  logic [W-1:0]       w_placed;
  logic [W-1:0]       w_word;
  logic [ENTRY_W-1:0] w_push_entry;
  logic [ENTRY_W-1:0] w_head;
  logic               w_full;
  logic               w_empty;
  logic [$clog2(DEPTH+1)-1:0] w_count;

  // ---------------------------------------------------------------------------
  // Input side
  // ---------------------------------------------------------------------------
  assign w_last   = (r_cnt == LAST_CNT);
  // Only the word-completing beat needs FIFO room; earlier beats just land in
  // the assembly register, so they are taken even while the FIFO is full.
  assign in_ready = !(w_last && w_full);
  assign w_accept = in_valid && in_ready;

  assign w_placed = W'(place_pair(in_a, in_cout, r_cnt));
  // Word as it stands after this cycle's pair (if any) is merged in.
  assign w_word   = w_accept ? (r_asm | w_placed) : r_asm;

  assign w_complete = w_accept && w_last;
  // A flush commits whenever there is at least one pair to commit (held or
  // arriving) and the FIFO has room; otherwise it is dropped and the source
  // re-asserts it later.
  assign w_push = w_complete ||
                  (flush && !w_full && ((r_cnt != '0) || w_accept));
  assign w_push_partial = !w_complete;

`ifdef PACK_PARITY_EN
  assign w_push_entry = {^w_word, w_push_partial, w_word};
`else
  assign w_push_entry = {w_push_partial, w_word};
`endif

  // ---------------------------------------------------------------------------
  // Assembler FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_asm   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_asm   <= w_asm_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_asm_next   = r_asm;
    unique case (r_state)
      ST_IDLE: begin
        // In IDLE a push can only come from flush with a same-cycle pair.
        if (w_push) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
          w_asm_next   = '0;
        end else if (w_accept) begin
          w_state_next = ST_FILL;
          w_cnt_next   = r_cnt + 1'b1;
          w_asm_next   = w_word;
        end
      end
      ST_FILL: begin
        if (w_push) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
          w_asm_next   = '0;
        end else if (w_accept) begin
          w_state_next = ST_FILL;
          w_cnt_next   = r_cnt + 1'b1;
          w_asm_next   = w_word;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
        w_asm_next   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  pack_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (out_ready),
    .o_head_data (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  assign out_valid        = !w_empty;
  assign out_data         = w_head[W-1:0];
  assign out_partial      = w_head[W];
`ifdef PACK_PARITY_EN
  assign out_parity       = w_head[W+1];
`endif
  assign o_dbg_state      = r_state;
  assign o_dbg_fifo_count = w_count;

endmodule
